// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator: state encoding and default widths.
package mac_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_ACC_WIDTH = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2
  } state_t;

endpackage

// File: rtl/mac_adder.sv
// Ripple-carry adder built from a chain of full-adder cells, carry-in tied to 0.
module mac_adder
  import mac_pkg::*;
#(
  parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH
) (
  input  logic [ACC_WIDTH-1:0] a_i,
  input  logic [ACC_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 cout_o
);

  logic [ACC_WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < ACC_WIDTH; i++) begin : g_fa
    assign sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[ACC_WIDTH];

endmodule

// File: rtl/mac_accumulator.sv
// Shift-and-add multiply followed by accumulate, with sticky overflow.
// Define MAC_SATURATE_EN to saturate the accumulator on overflow instead of wrapping.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 out_valid,
  output logic                 overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]   prod_q, prod_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic                   outv_q, outv_d;
  logic                   clrp_q, clrp_d;

  logic [ACC_WIDTH-1:0]   addend;
  logic [ACC_WIDTH-1:0]   add_a, add_b, add_sum;
  logic                   add_cout;

  // One adder serves both phases: partial products in MUL, accumulate in ACC.
  assign addend = b_q[0] ? (ACC_WIDTH'(a_q) << cnt_q) : '0;
  assign add_a  = (state_q == ST_MUL) ? prod_q : acc_q;
  assign add_b  = (state_q == ST_MUL) ? addend : prod_q;

  mac_adder #(.ACC_WIDTH(ACC_WIDTH)) u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    outv_d  = 1'b0;
    clrp_d  = clrp_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          prod_d  = '0;
          cnt_d   = '0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        prod_d = add_sum;
        b_d    = b_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (clear) clrp_d = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_ACC;
      end
      ST_ACC: begin
        // A clear seen during this operation replaces the sum rather than adding to it.
        if (clrp_q || clear) begin
          acc_d = prod_q;
          ovf_d = 1'b0;
        end else if (add_cout) begin
`ifdef MAC_SATURATE_EN
          acc_d = '1;
`else
          acc_d = add_sum;
`endif
          ovf_d = 1'b1;
        end else begin
          acc_d = add_sum;
        end
        clrp_d  = 1'b0;
        outv_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      outv_q  <= 1'b0;
      clrp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      outv_q  <= outv_d;
      clrp_q  <= clrp_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = outv_q;
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;

endmodule
